// File: rtl/movegen_sequencer.sv
// movegen_sequencer: control FSM for one move-generation pass over the square array.
//
// On start it pulses sq_clear for one cycle. It then holds sq_enable for PROP_CYCLES cycles.
// After that it scans every (square, direction) index through the external move mux.
// Qualifying words leave on a valid/ready stream. done pulses once at the end of a
// completed pass. Square-major scan order; directions 0..7 are U, D, L, R, UL, UR, DL, DR.
//
// Optional feature macro: MOVEGEN_SKIP_EMPTY_EN
//   defined   - zero move words are skipped and never occupy the output slot
//   undefined - every scanned word is emitted, zeros included
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             begin a pass (sampled only in IDLE)
//   engine_color_in   side to move, latched on an accepted start
//   abort             terminate the current pass, back to IDLE without done
//   sq_clear          one-cycle clear strobe to the array
//   sq_enable         array enable, high for PROP_CYCLES cycles
//   engine_color      latched side to move
//   sq_sel, dir_sel   scan index driving the external move mux
//   move_word         selected move word (combinational from sq_sel/dir_sel)
//   move_data         emitted move word
//   move_valid        move_data is valid
//   move_ready        downstream accepts the word
//   busy              high in every state except IDLE
//   done              one-cycle pulse when a pass completes
//   move_count        accepted words in the current or last pass (saturating)

module movegen_sequencer #(
  parameter int unsigned NUM_SQUARES = 4,
  parameter int unsigned NUM_DIRS    = 8,
  parameter int unsigned PROP_CYCLES = 8,
  parameter int unsigned COUNT_W     = 8,
  localparam int unsigned SQ_W = (NUM_SQUARES > 1) ? $clog2(NUM_SQUARES) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               engine_color_in,
  input  logic               abort,
  output logic               sq_clear,
  output logic               sq_enable,
  output logic               engine_color,
  output logic [SQ_W-1:0]    sq_sel,
  output logic [2:0]         dir_sel,
  input  logic [31:0]        move_word,
  output logic [31:0]        move_data,
  output logic               move_valid,
  input  logic               move_ready,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] move_count
);

  localparam int unsigned PROP_W = (PROP_CYCLES > 1) ? $clog2(PROP_CYCLES) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StProp,
    StCollect,
    StDrain,
    StDone
  } state_e;

  state_e              state_q;
  logic [PROP_W-1:0]   prop_cnt_q;
  logic [SQ_W-1:0]     sq_q;
  logic [2:0]          dir_q;
  logic [31:0]         data_q;
  logic                valid_q;
  logic                color_q;
  logic [COUNT_W-1:0]  count_q;

  logic slot_free;
  logic handshake;
  logic qualify;
  logic last_idx;

  // The output slot can take a new word when it is empty or its word leaves this cycle.
  assign slot_free = !valid_q || move_ready;
  assign handshake = valid_q && move_ready;
  assign last_idx  = (sq_q == SQ_W'(NUM_SQUARES - 1)) && (dir_q == 3'(NUM_DIRS - 1));

`ifdef MOVEGEN_SKIP_EMPTY_EN
  assign qualify = (move_word != 32'd0);
`else
  assign qualify = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      prop_cnt_q <= '0;
      sq_q       <= '0;
      dir_q      <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      color_q    <= 1'b0;
      count_q    <= '0;
    end else begin
      if (handshake) begin
        valid_q <= 1'b0;
        if (count_q != {COUNT_W{1'b1}}) begin
          count_q <= count_q + 1'b1;
        end
      end

      if (state_q != StIdle && abort) begin
        state_q <= StIdle;
        valid_q <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start && !abort) begin
              state_q <= StClear;
              color_q <= engine_color_in;
              count_q <= '0;
              sq_q    <= '0;
              dir_q   <= '0;
            end
          end
          StClear: begin
            state_q    <= StProp;
            prop_cnt_q <= PROP_W'(PROP_CYCLES - 1);
          end
          StProp: begin
            if (prop_cnt_q == '0) begin
              state_q <= StCollect;
            end else begin
              prop_cnt_q <= prop_cnt_q - 1'b1;
            end
          end
          StCollect: begin
            if (slot_free) begin
              if (qualify) begin
                data_q  <= move_word;
                valid_q <= 1'b1;
              end else begin
                valid_q <= 1'b0;
              end
              if (last_idx) begin
                state_q <= StDrain;
              end else if (dir_q == 3'(NUM_DIRS - 1)) begin
                dir_q <= '0;
                sq_q  <= sq_q + 1'b1;
              end else begin
                dir_q <= dir_q + 3'd1;
              end
            end
          end
          StDrain: begin
            if (slot_free) begin
              state_q <= StDone;
            end
          end
          StDone: begin
            state_q <= StIdle;
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  // Moore controls decoded from the state register.
  assign sq_clear     = (state_q == StClear);
  assign sq_enable    = (state_q == StProp);
  assign busy         = (state_q != StIdle);
  assign done         = (state_q == StDone);
  assign engine_color = color_q;
  assign sq_sel       = sq_q;
  assign dir_sel      = dir_q;
  assign move_data    = data_q;
  assign move_valid   = valid_q;
  assign move_count   = count_q;

endmodule
